// File: rtl/piezo_sched.sv
// piezo_sched: schedules fanfare notes for a downstream piezo tone generator.
//
// Three requests select a sequence over a six-note table:
//   too_fast (highest) - notes 0,1,2 looped with no gap
//   batt_low           - notes 5..0 looped with no gap
//   en_steer (lowest)  - notes 0..5, then a silent gap, repeated
// Requests are arbitrated only in IDLE, in GAP and at note boundaries, so a
// sounding note always plays its full length.
//
// Ports:
//   clk         - system clock (50 MHz), rising edge
//   rst         - synchronous active-high reset
//   too_fast    - request: first three fanfare notes, looped
//   batt_low    - request: fanfare backwards, looped
//   en_steer    - request: full fanfare, then silence, repeated
//   tone_period - half-rate tone period in clk cycles, 0 when silent
//   tone_en     - high while a note is sounding
//   note_start  - one-cycle pulse on the first cycle of each note
//   mode        - active request: 00 none, 01 en_steer, 10 batt_low, 11 too_fast
//
// Parameters:
//   FAST_SIM  - when 1, duration/gap counters advance by FAST_STEP per cycle
//   FAST_STEP - counter step used when FAST_SIM is 1 (16 by default)
module piezo_sched #(
    parameter bit          FAST_SIM  = 1'b0,
    parameter int unsigned FAST_STEP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        too_fast,
    input  logic        batt_low,
    input  logic        en_steer,
    output logic [14:0] tone_period,
    output logic        tone_en,
    output logic        note_start,
    output logic [1:0]  mode
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
    typedef enum logic [1:0] {
        M_NONE  = 2'b00,
        M_STEER = 2'b01,
        M_BATT  = 2'b10,
        M_FAST  = 2'b11
    } mode_t;

    localparam logic [25:0] STEP_D  = FAST_SIM ? 26'(FAST_STEP) : 26'd1;
    localparam logic [27:0] STEP_G  = FAST_SIM ? 28'(FAST_STEP) : 28'd1;
    localparam logic [27:0] GAP_LEN = 28'd150_000_000;

    function automatic logic [14:0] note_period(input logic [2:0] idx);
        case (idx)
            3'd0:    note_period = 15'd31888;
            3'd1:    note_period = 15'd23889;
            3'd2:    note_period = 15'd18961;
            3'd3:    note_period = 15'd15944;
            3'd4:    note_period = 15'd18961;
            3'd5:    note_period = 15'd15944;
            default: note_period = '0;
        endcase
    endfunction

    function automatic logic [25:0] note_dur(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: note_dur = 26'd8388608;
            3'd3:             note_dur = 26'd12582912;
            3'd4:             note_dur = 26'd4194304;
            3'd5:             note_dur = 26'd33554432;
            default:          note_dur = 26'd1;
        endcase
    endfunction

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [2:0]  pos_q, pos_d;
    logic [25:0] dcnt_q, dcnt_d;
    logic [27:0] gcnt_q, gcnt_d;
    logic        start_q, start_d;

    mode_t       win;
    logic [2:0]  idx;
    logic [2:0]  last_pos;
    logic [26:0] dsum;
    logic [28:0] gsum;
    logic        note_done;
    logic        gap_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= M_NONE;
            pos_q   <= '0;
            dcnt_q  <= '0;
            gcnt_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            dcnt_q  <= dcnt_d;
            gcnt_q  <= gcnt_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        if (too_fast)      win = M_FAST;
        else if (batt_low) win = M_BATT;
        else if (en_steer) win = M_STEER;
        else               win = M_NONE;

        // pos counts through the sequence; batt_low walks the table backwards.
        idx      = (mode_q == M_BATT) ? (3'd5 - pos_q) : pos_q;
        last_pos = (mode_q == M_FAST) ? 3'd2 : 3'd5;

        // Sums are one bit wider so the >= test cannot wrap with a large step.
        dsum      = {1'b0, dcnt_q} + {1'b0, STEP_D};
        gsum      = {1'b0, gcnt_q} + {1'b0, STEP_G};
        note_done = dsum >= {1'b0, note_dur(idx)};
        gap_done  = gsum >= {1'b0, GAP_LEN};
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pos_d   = pos_q;
        dcnt_d  = dcnt_q;
        gcnt_d  = gcnt_q;
        start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (win != M_NONE) begin
                    state_d = PLAY;
                    mode_d  = win;
                    pos_d   = '0;
                    dcnt_d  = '0;
                    start_d = 1'b1;
                end
            end
            PLAY: begin
                if (!note_done) begin
                    dcnt_d = dsum[25:0];
                end else begin
                    dcnt_d = '0;
                    if (win == M_NONE) begin
                        state_d = IDLE;
                        mode_d  = M_NONE;
                        pos_d   = '0;
                    end else if (win != mode_q) begin
                        mode_d  = win;
                        pos_d   = '0;
                        start_d = 1'b1;
                    end else if (pos_q == last_pos) begin
                        pos_d = '0;
                        if (mode_q == M_STEER) begin
                            state_d = GAP;
                            gcnt_d  = '0;
                        end else begin
                            start_d = 1'b1;
                        end
                    end else begin
                        pos_d   = pos_q + 3'd1;
                        start_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (too_fast || batt_low) begin
                    state_d = PLAY;
                    mode_d  = win;
                    pos_d   = '0;
                    dcnt_d  = '0;
                    start_d = 1'b1;
                end else if (!en_steer) begin
                    state_d = IDLE;
                    mode_d  = M_NONE;
                end else if (gap_done) begin
                    state_d = PLAY;
                    pos_d   = '0;
                    dcnt_d  = '0;
                    start_d = 1'b1;
                end else begin
                    gcnt_d = gsum[27:0];
                end
            end
            default: begin
                state_d = IDLE;
                mode_d  = M_NONE;
            end
        endcase
    end

    assign tone_en     = (state_q == PLAY);
    assign tone_period = tone_en ? note_period(idx) : '0;
    assign note_start  = start_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_piezo_sched.sv
// Self-checking bench for piezo_sched. Runs with FAST_SIM = 1 and a large
// FAST_STEP so that whole fanfare loops, including the silent gap, fit in a
// few thousand cycles. Expected notes (start cycle, period, mode) are queued
// when requests are driven and compared as note_start pulses appear.
module tb_piezo_sched;

    localparam int unsigned STEP = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        too_fast = 1'b0;
    logic        batt_low = 1'b0;
    logic        en_steer = 1'b0;
    logic [14:0] tone_period;
    logic        tone_en;
    logic        note_start;
    logic [1:0]  mode;

    piezo_sched #(.FAST_SIM(1'b1), .FAST_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .too_fast(too_fast), .batt_low(batt_low),
        .en_steer(en_steer), .tone_period(tone_period), .tone_en(tone_en),
        .note_start(note_start), .mode(mode)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic [14:0] period;
        logic [1:0]  mode;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned t_last = 0;
    int unsigned nxt;

    int unsigned per_tab[6] = '{31888, 23889, 18961, 15944, 18961, 15944};
    int unsigned dur_raw[6] = '{8388608, 8388608, 8388608, 12582912, 4194304, 33554432};
    int unsigned gap_cyc    = (150000000 + STEP - 1) / STEP;

    function automatic int unsigned dcyc(input int n);
        return (dur_raw[n] + STEP - 1) / STEP;
    endfunction

    // Queue a note expected at cycle nxt, then advance nxt past it.
    task automatic push_note(input int n, input logic [1:0] m);
        exp_t e;
        e.at = nxt;
        e.period = per_tab[n][14:0];
        e.mode = m;
        sb.push_back(e);
        nxt = nxt + dcyc(n);
    endtask

    task automatic expect_notes(input int count);
        exp_t e;
        bit found;
        for (int i = 0; i < count; i++) begin
            found = 0;
            for (int k = 0; k < 5000 && !found; k++) begin
                @(negedge clk);
                if (note_start) found = 1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL note_timeout got no note_start want note %0d of %0d", i, count);
                return;
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL note_unexpected got note_start at cycle %0d want none", cyc);
                return;
            end
            e = sb.pop_front();
            t_last = cyc;
            if (cyc !== e.at) begin
                errors++;
                $display("FAIL note_cycle got %0d want %0d", cyc, e.at);
            end
            checks++;
            if (tone_period !== e.period) begin
                errors++;
                $display("FAIL note_period got %0d want %0d", tone_period, e.period);
            end
            checks++;
            if (mode !== e.mode) begin
                errors++;
                $display("FAIL note_mode got %b want %b", mode, e.mode);
            end
            checks++;
            if (tone_en !== 1'b1) begin
                errors++;
                $display("FAIL note_tone_en got %b want 1", tone_en);
            end
        end
    endtask

    task automatic check_silent(input string name, input logic [1:0] want_mode);
        checks++;
        if (tone_en !== 1'b0 || tone_period !== 15'd0 || note_start !== 1'b0 || mode !== want_mode) begin
            errors++;
            $display("FAIL %s got en=%b per=%0d start=%b mode=%b want en=0 per=0 start=0 mode=%b",
                     name, tone_en, tone_period, note_start, mode, want_mode);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_silent("reset_outputs", 2'b00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_silent("idle_no_request", 2'b00);
    endtask

    task automatic test_en_steer;
        en_steer = 1'b1;
        nxt = cyc + 1;
        for (int n = 0; n < 6; n++) push_note(n, 2'b01);
        expect_notes(6);
        repeat (dcyc(5)) @(negedge clk);
        check_silent("gap_first_cycle", 2'b01);
        nxt = t_last + dcyc(5) + gap_cyc;
        push_note(0, 2'b01);
        expect_notes(1);
    endtask

    // Entered on the negedge where note 0 has just started.
    task automatic test_drop;
        en_steer = 1'b0;
        repeat (dcyc(0) - 1) @(negedge clk);
        checks++;
        if (tone_en !== 1'b1 || tone_period !== 15'd31888) begin
            errors++;
            $display("FAIL drop_last_cycle got en=%b per=%0d want en=1 per=31888", tone_en, tone_period);
        end
        @(negedge clk);
        check_silent("drop_idle", 2'b00);
    endtask

    task automatic test_too_fast;
        too_fast = 1'b1;
        nxt = cyc + 1;
        push_note(0, 2'b11);
        push_note(1, 2'b11);
        push_note(2, 2'b11);
        push_note(0, 2'b11);
        push_note(1, 2'b11);
        expect_notes(5);
    endtask

    // Switch from too_fast to batt_low right at a note start; note 1 must finish.
    task automatic test_back_to_back;
        too_fast = 1'b0;
        batt_low = 1'b1;
        nxt = t_last + dcyc(1);
        for (int n = 5; n >= 0; n--) push_note(n, 2'b10);
        push_note(5, 2'b10);
        expect_notes(7);
        batt_low = 1'b0;
        repeat (dcyc(5)) @(negedge clk);
        check_silent("batt_drop_idle", 2'b00);
    endtask

    task automatic test_preempt;
        en_steer = 1'b1;
        nxt = cyc + 1;
        push_note(0, 2'b01);
        push_note(1, 2'b01);
        expect_notes(2);
        repeat (10) @(negedge clk);
        too_fast = 1'b1;
        nxt = t_last + dcyc(1);
        push_note(0, 2'b11);
        push_note(1, 2'b11);
        expect_notes(2);
        too_fast = 1'b0;
        en_steer = 1'b0;
        repeat (dcyc(1)) @(negedge clk);
        check_silent("preempt_idle", 2'b00);
    endtask

    task automatic test_reset_gap;
        en_steer = 1'b1;
        nxt = cyc + 1;
        for (int n = 0; n < 6; n++) push_note(n, 2'b01);
        expect_notes(6);
        repeat (dcyc(5) + 100) @(negedge clk);
        check_silent("mid_gap", 2'b01);
        rst = 1'b1;
        @(negedge clk);
        check_silent("reset_in_gap", 2'b00);
        rst = 1'b0;
        nxt = cyc + 1;
        push_note(0, 2'b01);
        expect_notes(1);
        en_steer = 1'b0;
        repeat (dcyc(0)) @(negedge clk);
        check_silent("final_idle", 2'b00);
    endtask

    initial begin
        test_reset();
        test_en_steer();
        test_drop();
        test_too_fast();
        test_back_to_back();
        test_preempt();
        test_reset_gap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
